// File: rtl/machine_line_pkg.sv
// machine_line_pkg: character codes, parser states and the digit test shared by the line parser.
package machine_line_pkg;

    localparam logic [7:0] CH_LBRACK = 8'h5B;
    localparam logic [7:0] CH_RBRACK = 8'h5D;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_LPAREN = 8'h28;
    localparam logic [7:0] CH_RPAREN = 8'h29;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        LIGHTS,
        SEEK,
        BUTTON,
        JOLT,
        DISCARD,
        ISSUE,
        WAIT_DONE
    } parser_state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

endpackage

// File: rtl/machine_line_parser_decimal_accumulator.sv
// decimal_accumulator: builds a multi-digit decimal index as acc*10+digit, saturating at all-ones.
module decimal_accumulator #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [3:0]   i_digit,
    output logic [W-1:0] o_value,
    output logic         o_has_digit
);

    logic [W-1:0] r_value;
    logic         r_has_digit;
    logic [W+3:0] w_next;

    // four spare bits keep acc*10+9 from wrapping before the saturation test
    assign w_next      = {4'b0000, r_value} * (W + 4)'(10) + (W + 4)'(i_digit);
    assign o_value     = r_value;
    assign o_has_digit = r_has_digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value     <= '0;
            r_has_digit <= 1'b0;
        end else if (i_clear) begin
            r_value     <= '0;
            r_has_digit <= 1'b0;
        end else if (i_load) begin
            r_value     <= (w_next > (W + 4)'({W{1'b1}})) ? '1 : w_next[W-1:0];
            r_has_digit <= 1'b1;
        end
    end

endmodule

// File: rtl/machine_line_parser.sv
// machine_line_parser: decodes one "[lights] (buttons)... {joltage}" line per s_tlast into solver inputs
// and issues a one-cycle start when the solver is idle; malformed lines raise parse_err instead.
module machine_line_parser
    import machine_line_pkg::*;
#(
    parameter int MAX_NUM_LIGHTS    = 6,
    parameter int MAX_NUM_BUTTONS   = 6,
    parameter int MAX_NUM_LIGHTS_W  = (MAX_NUM_LIGHTS <= 1) ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
    parameter int MAX_NUM_BUTTONS_W = (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1)
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [7:0]                                      s_tdata,
    input  logic                                            s_tvalid,
    output logic                                            s_tready,
    input  logic                                            s_tlast,
    output logic [MAX_NUM_LIGHTS_W-1:0]                     num_lights,
    output logic [MAX_NUM_BUTTONS_W-1:0]                    num_buttons,
    output logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]  buttons,
    output logic [MAX_NUM_LIGHTS-1:0]                       target_lights_arrangement,
    output logic                                            start,
    input  logic                                            ready,
    output logic                                            parse_err
);

    localparam int AW = MAX_NUM_LIGHTS_W + 1;

    parser_state_e r_state, w_next, w_go;
    logic [MAX_NUM_LIGHTS_W-1:0]                    r_num_lights;
    logic [MAX_NUM_BUTTONS_W-1:0]                   r_num_buttons;
    logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] r_buttons;
    logic [MAX_NUM_LIGHTS-1:0]                      r_target;
    logic                                           r_start;
    logic                                           r_parse_err;

    logic                      w_beat, w_ok, w_good, w_drop, w_clear;
    logic                      w_is_light, w_sep, w_digit, w_bad_idx, w_set_bit;
    logic                      w_lights_full, w_buttons_full, w_no_lights;
    logic                      w_has_digit;
    logic [AW-1:0]             w_acc;
    logic [MAX_NUM_LIGHTS-1:0] w_light_mask, w_bit_mask;

    assign w_beat         = s_tvalid && s_tready;
    assign w_is_light     = (s_tdata == CH_DOT) || (s_tdata == CH_HASH);
    assign w_sep          = (s_tdata == CH_COMMA) || (s_tdata == CH_RPAREN);
    assign w_digit        = is_digit(s_tdata);
    assign w_lights_full  = r_num_lights == MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS);
    assign w_buttons_full = r_num_buttons == MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS);
    assign w_no_lights    = r_num_lights == '0;
    assign w_bad_idx      = !w_has_digit || (w_acc >= AW'(r_num_lights));
    assign w_good         = w_beat && w_ok;
    assign w_set_bit      = w_good && (r_state == BUTTON) && w_sep;
    // a rejected beat carrying s_tlast ends the line directly, so DISCARD is skipped
    assign w_drop         = w_beat && s_tlast && (!w_ok || (r_state == DISCARD));
    assign w_clear        = (r_state != IDLE) && (w_next == IDLE);
    assign w_light_mask   = (s_tdata == CH_HASH) ? (MAX_NUM_LIGHTS'(1) << r_num_lights) : '0;
    assign w_bit_mask     = MAX_NUM_LIGHTS'(1) << w_acc;

    decimal_accumulator #(.W(AW)) u_acc (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_set_bit || (r_state != BUTTON)),
        .i_load      (w_good && (r_state == BUTTON) && w_digit),
        .i_digit     (s_tdata[3:0]),
        .o_value     (w_acc),
        .o_has_digit (w_has_digit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_ok = 1'b1;
        w_go = r_state;
        case (r_state)
            IDLE: begin
                w_ok = (s_tdata == CH_LBRACK) && !s_tlast;
                w_go = LIGHTS;
            end
            LIGHTS: begin
                w_ok = !s_tlast && ((w_is_light && !w_lights_full) || (s_tdata == CH_RBRACK));
                w_go = (s_tdata == CH_RBRACK) ? SEEK : LIGHTS;
            end
            SEEK: begin
                w_ok = ((s_tdata == CH_SPACE) || (s_tdata == CH_LBRACE) ||
                        ((s_tdata == CH_LPAREN) && !w_buttons_full && !s_tlast)) &&
                       !(s_tlast && w_no_lights);
                w_go = s_tlast ? ISSUE : (s_tdata == CH_LPAREN) ? BUTTON :
                       (s_tdata == CH_LBRACE) ? JOLT : SEEK;
            end
            BUTTON: begin
                w_ok = !s_tlast && (w_digit || (w_sep && !w_bad_idx));
                w_go = (s_tdata == CH_RPAREN) ? SEEK : BUTTON;
            end
            JOLT: begin
                w_ok = !(s_tlast && w_no_lights);
                w_go = s_tlast ? ISSUE : JOLT;
            end
            DISCARD:   w_go = s_tlast ? IDLE : DISCARD;
            ISSUE:     w_go = ready ? WAIT_DONE : ISSUE;
            // r_start marks the first WAIT_DONE cycle, whose ready is still the stale idle level
            WAIT_DONE: w_go = (ready && !r_start) ? IDLE : WAIT_DONE;
        endcase
        w_next = ((r_state == ISSUE) || (r_state == WAIT_DONE)) ? w_go :
                 !w_beat ? r_state :
                 !w_ok ? (s_tlast ? IDLE : DISCARD) : w_go;
    end

    always_comb begin
        s_tready                  = !rst && (r_state != ISSUE) && (r_state != WAIT_DONE);
        start                     = r_start;
        parse_err                 = r_parse_err;
        num_lights                = r_num_lights;
        num_buttons               = r_num_buttons;
        buttons                   = r_buttons;
        target_lights_arrangement = r_target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start       <= 1'b0;
            r_parse_err   <= 1'b0;
            r_num_lights  <= '0;
            r_num_buttons <= '0;
            r_buttons     <= '0;
            r_target      <= '0;
        end else begin
            r_start     <= (r_state == ISSUE) && ready;
            r_parse_err <= w_drop;
            if (w_clear) begin
                r_num_lights  <= '0;
                r_num_buttons <= '0;
                r_buttons     <= '0;
                r_target      <= '0;
            end else if (w_good) begin
                if ((r_state == LIGHTS) && w_is_light) begin
                    r_target     <= r_target | w_light_mask;
                    r_num_lights <= r_num_lights + MAX_NUM_LIGHTS_W'(1);
                end
                if ((r_state == SEEK) && (s_tdata == CH_LPAREN))
                    r_num_buttons <= r_num_buttons + MAX_NUM_BUTTONS_W'(1);
                for (int b = 0; b < MAX_NUM_BUTTONS; b++)
                    if (w_set_bit && (MAX_NUM_BUTTONS_W'(b + 1) == r_num_buttons))
                        r_buttons[b] <= r_buttons[b] | w_bit_mask;
            end
        end
    end

endmodule

// File: tb/tb_machine_line_parser.sv
// tb_machine_line_parser: scenario tasks drive lines; a negedge monitor checks start/parse_err against a scoreboard.
module tb_machine_line_parser;

    localparam int NL  = 12;
    localparam int NB  = 6;
    localparam int NLW = 4;
    localparam int NBW = 3;

    localparam string NOMINAL = "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}";
    localparam string GOOD2   = "[#..#] (0,3) (1) {1}";
    localparam string GOOD3   = "[#.#] (1) (0,2) {5}";
    localparam string GAPLINE = "[#.........#.] (10) (0,11) {2}";

    typedef struct packed {
        logic             err;
        logic [NLW-1:0]   nl;
        logic [NBW-1:0]   nb;
        logic [NL-1:0]    tgt;
        logic [NB*NL-1:0] btn;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] s_tdata = 8'h00;
    logic s_tvalid = 1'b0;
    logic s_tlast = 1'b0;
    logic ready = 1'b1;
    logic s_tready, start, parse_err;
    logic [NLW-1:0] num_lights;
    logic [NBW-1:0] num_buttons;
    logic [NB-1:0][NL-1:0] buttons;
    logic [NL-1:0] target;

    exp_t sb[$];
    exp_t got;
    logic ready_seen = 1'b0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    machine_line_parser #(
        .MAX_NUM_LIGHTS  (NL),
        .MAX_NUM_BUTTONS (NB)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_tdata                   (s_tdata),
        .s_tvalid                  (s_tvalid),
        .s_tready                  (s_tready),
        .s_tlast                   (s_tlast),
        .num_lights                (num_lights),
        .num_buttons               (num_buttons),
        .buttons                   (buttons),
        .target_lights_arrangement (target),
        .start                     (start),
        .ready                     (ready),
        .parse_err                 (parse_err)
    );

    function automatic exp_t mk(input logic err, input int nl, input int nb,
                                input logic [NL-1:0] tgt, input logic [NB*NL-1:0] btn);
        exp_t e;
        e.err = err;
        e.nl  = NLW'(nl);
        e.nb  = NBW'(nb);
        e.tgt = tgt;
        e.btn = btn;
        return e;
    endfunction

    function automatic exp_t nominal_exp();
        return mk(1'b0, 4, 6, 12'h006, {12'h003, 12'h005, 12'h00C, 12'h004, 12'h00A, 12'h008});
    endfunction

    function automatic exp_t err_exp();
        return mk(1'b1, 0, 0, '0, '0);
    endfunction

    // scoreboard monitor: every start or parse_err consumes the oldest expectation
    initial forever begin
        @(negedge clk);
        if (start) begin
            checks++;
            if (!ready_seen) begin
                errors++;
                $display("FAIL start_while_busy: start=1 with ready=0 in the previous cycle, required ready=1");
            end
        end
        if (start || parse_err) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: start=%0b parse_err=%0b, required no output", start, parse_err);
            end else begin
                got = sb.pop_front();
                if ({start, parse_err} !== {~got.err, got.err}) begin
                    errors++;
                    $display("FAIL outcome: start=%0b parse_err=%0b, required start=%0b parse_err=%0b",
                             start, parse_err, ~got.err, got.err);
                end else if (!got.err && ({num_lights, num_buttons, target, buttons} !== {got.nl, got.nb, got.tgt, got.btn})) begin
                    errors++;
                    $display("FAIL decode: nl=%0d nb=%0d tgt=%h btn=%h, required nl=%0d nb=%0d tgt=%h btn=%h",
                             num_lights, num_buttons, target, buttons, got.nl, got.nb, got.tgt, got.btn);
                end
            end
        end
        ready_seen = ready;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n = 0;
        while (!s_tready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!s_tready) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout: s_tready=0 after 200 cycles, required 1");
        end
    endtask

    task automatic send_line(input string s, input bit last, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            if (gap > 0) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(0, gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
            s_tdata  = s[i];
            s_tvalid = 1'b1;
            s_tlast  = last && (i == s.len() - 1);
            wait_ready();
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_tready, start, parse_err, num_lights, num_buttons, target, buttons} !== '0) begin
            errors++;
            $display("FAIL reset_values: tready=%0b start=%0b err=%0b nl=%0d nb=%0d tgt=%h, required all 0",
                     s_tready, start, parse_err, num_lights, num_buttons, target);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL idle_tready: s_tready=%0b, required 1", s_tready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_nominal();
        sb.push_back(nominal_exp());
        send_line(NOMINAL, 1'b1, 0);
        checks++;
        if (s_tready !== 1'b0 || start !== 1'b0) begin
            errors++;
            $display("FAIL issue_cycle: tready=%0b start=%0b, required tready=0 start=0", s_tready, start);
        end
        @(posedge clk);
        #1;
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: start=%0b two cycles after tlast, required 1", start);
        end
        @(posedge clk);
        #1;
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse: start=%0b, required 0", start);
        end
        wait_ready();
    endtask

    task automatic test_busy();
        ready = 1'b0;
        sb.push_back(nominal_exp());
        send_line(NOMINAL, 1'b1, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (start !== 1'b0 || s_tready !== 1'b0 || num_lights !== 4'd4 || num_buttons !== 3'd6 || target !== 12'h006) begin
                errors++;
                $display("FAIL busy_hold: start=%0b tready=%0b nl=%0d nb=%0d tgt=%h, required 0 0 4 6 006",
                         start, s_tready, num_lights, num_buttons, target);
            end
            @(posedge clk);
            #1;
        end
        ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: start=%0b after ready rose, required 1", start);
        end
        wait_ready();
    endtask

    task automatic test_index_range();
        sb.push_back(err_exp());
        sb.push_back(mk(1'b0, 4, 2, 12'h009, {48'h0, 12'h002, 12'h009}));
        send_line("[#..#] (4) {1}", 1'b1, 0);
        checks++;
        if (parse_err !== 1'b1 || start !== 1'b0) begin
            errors++;
            $display("FAIL index_err: parse_err=%0b start=%0b, required 1 0", parse_err, start);
        end
        send_line(GOOD2, 1'b1, 0);
        wait_ready();
    endtask

    task automatic test_errors();
        string bad [5] = '{"[##] (0) (1) (0) (1) (0) (1) (0) {1}", "[.#.", "[] {1}",
                           "[#] (,0) {1}", "[#] x {1}"};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(err_exp());
            send_line(bad[i], 1'b1, 0);
            checks++;
            if (parse_err !== 1'b1 || start !== 1'b0) begin
                errors++;
                $display("FAIL bad_line_%0d: parse_err=%0b start=%0b, required 1 0", i, parse_err, start);
            end
        end
    endtask

    task automatic test_gaps();
        exp_t e = mk(1'b0, 12, 2, 12'h401, {48'h0, 12'h801, 12'h400});
        sb.push_back(e);
        send_line(GAPLINE, 1'b1, 0);
        wait_ready();
        sb.push_back(e);
        send_line(GAPLINE, 1'b1, 3);
        wait_ready();
    endtask

    task automatic test_reset_mid();
        send_line("[#.#] (1", 1'b0, 0);
        checks++;
        if (num_lights !== 4'd3 || num_buttons !== 3'd1) begin
            errors++;
            $display("FAIL partial_line: nl=%0d nb=%0d, required 3 1", num_lights, num_buttons);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({s_tready, start, parse_err, num_lights, num_buttons, target, buttons} !== '0) begin
            errors++;
            $display("FAIL async_reset: tready=%0b nl=%0d nb=%0d tgt=%h, required all 0",
                     s_tready, num_lights, num_buttons, target);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready: s_tready=%0b during reset, required 0", s_tready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb.push_back(mk(1'b0, 3, 2, 12'h005, {48'h0, 12'h005, 12'h002}));
        send_line(GOOD3, 1'b1, 0);
        wait_ready();
    endtask

    task automatic test_back_to_back();
        sb.push_back(nominal_exp());
        sb.push_back(mk(1'b0, 3, 2, 12'h005, {48'h0, 12'h005, 12'h002}));
        send_line(NOMINAL, 1'b1, 0);
        send_line(GOOD3, 1'b1, 0);
        wait_ready();
    endtask

    initial begin
        int n = 0;
        test_reset();
        test_nominal();
        test_busy();
        test_index_range();
        test_errors();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unmatched, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/machine_line_parser.md
# machine_line_parser

Front-end loader for `configure_machine`. It accepts one ASCII machine description per line on an 8-bit AXI-stream sink and decodes three fields: the bracketed light pattern, the parenthesised button wiring lists, and the braced joltage list, which is skipped. It presents `num_lights`, `num_buttons`, `buttons` and `target_lights_arrangement` to `configure_machine` and pulses `start` when the solver is idle. Malformed lines are dropped and reported, and no solve is issued for them.

## Interface
- `MAX_NUM_LIGHTS`, default 6: maximum lights per machine.
- `MAX_NUM_BUTTONS`, default 6: maximum buttons per machine.
- `MAX_NUM_LIGHTS_W`, derived: `(MAX_NUM_LIGHTS<=1) ? 1 : $clog2(MAX_NUM_LIGHTS+1)`.
- `MAX_NUM_BUTTONS_W`, derived: the same formula applied to `MAX_NUM_BUTTONS`.
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `s_tdata`  in  8: ASCII character.
- `s_tvalid`  in  1: character valid.
- `s_tready`  out  1: parser accepts the character.
- `s_tlast`  in  1: last character of the line.
- `num_lights`  out  `MAX_NUM_LIGHTS_W`: decoded light count.
- `num_buttons`  out  `MAX_NUM_BUTTONS_W`: decoded button count.
- `buttons`  out  `[MAX_NUM_LIGHTS-1:0]` × `MAX_NUM_BUTTONS`: bit i of `buttons[b]` is set when button b toggles light i.
- `target_lights_arrangement`  out  `MAX_NUM_LIGHTS`: bit i is set when light i is '#'.
- `start`  out  1: one-cycle solve request.
- `ready`  in  1: the solver is idle. It deasserts the cycle after it samples `start` and reasserts when the solution is emitted.
- `parse_err`  out  1: one-cycle pulse when a line is dropped.

## Operation
- **Grammar.** A line is `'['` {`'.'`|`'#'`} `']'`, then groups of `'('` idx{`','`idx} `')'`, then `'{'` … `'}'`.
  - Spaces are legal between groups.
  - Light index 0 is the first character after `'['`.
  - Indices are decimal and may be multi-digit. They accumulate as `acc*10+digit`, saturating at all-ones.
- **States.**
  - `IDLE`: expects `'['`. On entry, clears `target`, all `buttons` and both counts.
  - `LIGHTS`: on `'.'`/`'#'`, writes the bit and increments `num_lights`. On `']'`, goes to `SEEK`.
  - `SEEK`: space stays in `SEEK`. `'('` allocates the next button (`num_buttons++`) and goes to `BUTTON`. `'{'` goes to `JOLT`.
  - `BUTTON`: a digit accumulates. `','` or `')'` sets bit `acc` of the current button and clears `acc`. `')'` then returns to `SEEK`.
  - `JOLT`: consumes everything until the accepted beat with `s_tlast`.
  - `DISCARD`: consumes until `s_tlast`, pulses `parse_err`, then goes to `IDLE`.
  - `ISSUE`: holds until `ready=1`, then drives `start=1` for one cycle and goes to `WAIT_DONE`.
  - `WAIT_DONE`: ignores `ready` in the first cycle. Returns to `IDLE` on the first later cycle with `ready=1`.
- **Successful line.** An accepted `s_tlast` in `JOLT` or `SEEK`, with `num_lights≥1`, goes to `ISSUE`. Zero buttons is legal.
- **Errors.** Each of the following sends the parser to `DISCARD`:
  - any unexpected character;
  - a light beyond `MAX_NUM_LIGHTS`;
  - a `'('` beyond `MAX_NUM_BUTTONS`;
  - an index ≥ `num_lights`;
  - `')'` or `','` with no preceding digit.
- **Early `s_tlast`.** A `s_tlast` in `IDLE`, `LIGHTS` or `BUTTON` is an error. It pulses `parse_err` in the following cycle and goes to `IDLE`; no discard phase is needed.
- **Output stability.** Decoded outputs stay stable from `ISSUE` until the next `IDLE` entry. `configure_machine` samples them throughout the solve.

## Timing
- **Reset values.** While `rst` is high, all outputs are 0, including `s_tready`. After reset the state is `IDLE`.
- **`s_tready`.** Equals 1 in `IDLE`, `LIGHTS`, `SEEK`, `BUTTON`, `JOLT` and `DISCARD`. Equals 0 in `ISSUE` and `WAIT_DONE`. It depends only on state and never on `s_tvalid`.
- **Throughput.** One character per cycle; a character is accepted when `s_tvalid && s_tready`.
- **Start latency.**
  - The last beat is accepted in cycle N; the state is `ISSUE` in cycle N+1.
  - If `ready` is high in N+1, `start` is high in N+2. The decision is registered, so `start` is a flop output.
  - If `ready` is low, `start` waits, and `start` never asserts while `ready=0`.
- **`parse_err`.** Registered; high in the cycle after the terminating `s_tlast` beat.
- **Reset mid-line.** Asynchronous; the partial line is lost. The bench restarts the stream at a line boundary.

## Structure
- **Package `machine_line_pkg`:**
  - character constants (`CH_LBRACK`, `CH_RBRACK`, `CH_DOT`, `CH_HASH`, `CH_LPAREN`, `CH_RPAREN`, `CH_COMMA`, `CH_LBRACE`, `CH_SPACE`);
  - `parser_state_e` enum;
  - an `is_digit` function.
- **Sub-module `decimal_accumulator`:** clear/load-digit inputs and a saturating value output of width `MAX_NUM_LIGHTS_W+1`.

## Test plan
- **Nominal line.** Stimulus: `[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}` with `s_tlast` on `'}'` and `ready=1`. Required:
  - `num_lights=4`, `target=6'b000110`, `num_buttons=6`;
  - `buttons[0..5] = 001000, 001010, 000100, 001100, 000101, 000011`;
  - `start` high exactly 2 cycles after the tlast beat.
- **Busy solver.** Stimulus: the same line with `ready=0` for 10 cycles after tlast. Required: `start` delayed until `ready` rises, `s_tready=0` throughout, outputs stable.
- **Index out of range.** Stimulus: `[#..#] (4) {1}`. Required: a single `parse_err` pulse and no `start`. A following valid line then yields the correct `start`.
- **Too many buttons.** Stimulus: 7 button groups with `MAX_NUM_BUTTONS=6`. Required: `parse_err`, no `start`.
- **Backpressure / gaps.** Stimulus: random `s_tvalid` gaps and a multi-digit index `(10)` under `MAX_NUM_LIGHTS=12`. Required: results identical to the gap-free run, and bit 10 is set.
- **Reset mid-line.** Stimulus: `rst` pulse during `BUTTON`. Required: all outputs 0 immediately, `s_tready=0` during reset. The next full line parses correctly.
